// File: rtl/pipe_pkg.sv
// Purpose : shared Y86-64 encodings (icode, stat, register id) and controller FSM states.
// Latency : n/a (constants, types and a helper function only).
// Backpressure: n/a.
package pipe_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Status codes
  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  // Register id meaning "no register"
  localparam logic [3:0] R_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // A status that stops the machine once it reaches write-back.
  function automatic logic is_exc(input logic [3:0] stat);
    return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Purpose : bundles pipeline-register status into the controller and stage controls/diagnostics out.
// Latency : n/a (wires only).
// Backpressure: n/a; stalls/bubbles themselves are the pipeline's flow control.
// Ports   : master = controller side (reads stage status, drives controls and counters);
//           slave  = datapath side (drives stage status, obeys controls).
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       D_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_icode;
  logic [3:0]       E_dstM;
  logic             e_cnd;
  logic [3:0]       M_icode;
  logic [3:0]       m_stat;
  logic [3:0]       W_stat;
  logic [3:0]       W_icode;

  logic             F_stall;
  logic             D_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             W_stall;
  logic             set_cc;
  logic             halted;
  logic             error;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd,
           M_icode, m_stat, W_stat, W_icode,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
           set_cc, halted, error, cycle_cnt, retire_cnt, stall_cnt
  );

  modport slave (
    output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd,
           M_icode, m_stat, W_stat, W_icode,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
           set_cc, halted, error, cycle_cnt, retire_cnt, stall_cnt
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Purpose : raw hazard/exception conditions seen in the current pipeline-register contents.
// Latency : purely combinational, same cycle.
// Backpressure: none; results are consumed by the controller FSM.
// Ports   : stage icodes/register ids/status in; lu (load/use), rt (ret in flight),
//           mp (mispredicted jump), exm/exw (exception in M / W) out.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [3:0] D_icode_i,
  input  logic [3:0] d_srcA_i,
  input  logic [3:0] d_srcB_i,
  input  logic [3:0] E_icode_i,
  input  logic [3:0] E_dstM_i,
  input  logic       e_cnd_i,
  input  logic [3:0] M_icode_i,
  input  logic [3:0] m_stat_i,
  input  logic [3:0] W_stat_i,
  output logic       lu_o,
  output logic       rt_o,
  output logic       mp_o,
  output logic       exm_o,
  output logic       exw_o
);

  // A load in E whose destination is a source of the instruction in D.
  // R_NONE never matches, even if decode also reports R_NONE.
  assign lu_o = ((E_icode_i == I_MRMOVQ) || (E_icode_i == I_POPQ)) &&
                (E_dstM_i != R_NONE) &&
                ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));

  assign rt_o = (D_icode_i == I_RET) || (E_icode_i == I_RET) || (M_icode_i == I_RET);

  // Jumps are predicted taken, so a not-taken condition is a mispredict.
  assign mp_o = (E_icode_i == I_JXX) && !e_cnd_i;

  assign exm_o = is_exc(m_stat_i);
  assign exw_o = is_exc(W_stat_i);

endmodule

// File: rtl/pipe_ctrl.sv
// Purpose : Y86-64 pipeline hazard/sequencing controller with startup fill, halt/error freeze
//           and saturating diagnostic counters.
// Latency : stage controls are combinational in RUN; state, halted/error and counters update on clk.
// Backpressure: none accepted; it is the source of pipeline stalls and bubbles.
// Ports   : clk, rst (async, active-high); pif (master) carries stage status in and
//           F/D/W stalls, D/E/M bubbles, set_cc, halted, error and counters out.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int FILL_CYCLES = 4,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.master pif
);

  localparam int FW = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;

  logic lu, rt, mp, exm, exw;

  hazard_detect u_hazard (
    .D_icode_i (pif.D_icode),
    .d_srcA_i  (pif.d_srcA),
    .d_srcB_i  (pif.d_srcB),
    .E_icode_i (pif.E_icode),
    .E_dstM_i  (pif.E_dstM),
    .e_cnd_i   (pif.e_cnd),
    .M_icode_i (pif.M_icode),
    .m_stat_i  (pif.m_stat),
    .W_stat_i  (pif.W_stat),
    .lu_o      (lu),
    .rt_o      (rt),
    .mp_o      (mp),
    .exm_o     (exm),
    .exw_o     (exw)
  );

  state_e           state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             halted_q, halted_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc;

  // Stage controls. rst is looked at directly so the pipeline sees bubbles
  // (but no fetch stall) for as long as reset is held.
  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    d_bubble = 1'b0;
    e_bubble = 1'b0;
    m_bubble = 1'b0;
    w_stall  = 1'b0;
    set_cc   = 1'b0;
    if (rst) begin
      d_bubble = 1'b1;
      e_bubble = 1'b1;
      m_bubble = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          f_stall  = lu || rt;
          d_stall  = lu;
          // A load/use stall on D takes priority over the ret bubble.
          d_bubble = mp || (!lu && rt);
          e_bubble = mp || lu;
          m_bubble = exm || exw;
          w_stall  = exw;
          // Never let an instruction behind an exception change the CCs.
          set_cc   = (pif.E_icode == I_OPQ) && !exm && !exw;
        end
        ST_HALT, ST_ERR: begin
          f_stall  = 1'b1;
          d_stall  = 1'b1;
          w_stall  = 1'b1;
          m_bubble = 1'b1;
        end
        default: begin  // ST_FILL
          f_stall  = 1'b1;
          d_bubble = 1'b1;
          e_bubble = 1'b1;
          m_bubble = 1'b1;
        end
      endcase
    end
  end

  // Next state and counters.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    halted_d = halted_q;
    error_d  = error_q;
    cycle_d  = cycle_q;
    retire_d = retire_q;
    stall_d  = stall_q;
    case (state_q)
      ST_FILL: begin
        fill_d = fill_q + 1'b1;
        if (fill_q == FW'(FILL_CYCLES - 1)) begin
          state_d = ST_RUN;
          fill_d  = '0;
        end
      end
      ST_RUN: begin
        if (!(&cycle_q)) cycle_d = cycle_q + 1'b1;
        if (f_stall && !(&stall_q)) stall_d = stall_q + 1'b1;
        if ((pif.W_stat == S_AOK) && (pif.W_icode != I_NOP) && !w_stall && !(&retire_q))
          retire_d = retire_q + 1'b1;
        if (pif.W_stat == S_HLT) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else if ((pif.W_stat == S_ADR) || (pif.W_stat == S_INS)) begin
          state_d = ST_ERR;
          error_d = 1'b1;
        end
      end
      default: ;  // HALT / ERR are terminal; everything holds
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FILL;
      fill_q   <= '0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
      cycle_q  <= '0;
      retire_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      halted_q <= halted_d;
      error_q  <= error_d;
      cycle_q  <= cycle_d;
      retire_q <= retire_d;
      stall_q  <= stall_d;
    end
  end

  assign pif.F_stall    = f_stall;
  assign pif.D_stall    = d_stall;
  assign pif.D_bubble   = d_bubble;
  assign pif.E_bubble   = e_bubble;
  assign pif.M_bubble   = m_bubble;
  assign pif.W_stall    = w_stall;
  assign pif.set_cc     = set_cc;
  assign pif.halted     = halted_q;
  assign pif.error      = error_q;
  assign pif.cycle_cnt  = cycle_q;
  assign pif.retire_cnt = retire_q;
  assign pif.stall_cnt  = stall_q;

endmodule
